// File: rtl/cp0_unit_if.sv
// ---------------------------------------------------------------------------
// cp0_unit_if
// Groups the signals passed between the M stage and coprocessor 0.
//   master : the pipeline side. It drives the mtc0 write, the M-stage PC,
//            the branch-delay flag, the exception code, the interrupt lines
//            and eret. It receives the read data, EPC, the flush request and
//            EXL.
//   slave  : the cp0_unit side, with every direction reversed.
// Signals:
//   en, cp0_addr, cp0_wdata  mtc0 write enable, register number, write data
//   vpc, bd_in               PC of the M instruction, delay-slot flag
//   exc_code_in              pipelined exception code (0 = none)
//   hw_int                   level-sensitive external interrupt lines
//   eret                     eret is in M
//   cp0_rdata                mfc0 read data (combinational)
//   epc_out                  current EPC
//   req                      take an interrupt/exception this cycle
//   exl_out                  SR.EXL
// ---------------------------------------------------------------------------
interface cp0_unit_if;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic [31:0] cp0_rdata;
    logic [31:0] epc_out;
    logic        req;
    logic        exl_out;

    modport master (
        output en, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, hw_int, eret,
        input  cp0_rdata, epc_out, req, exl_out
    );

    modport slave (
        input  en, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, hw_int, eret,
        output cp0_rdata, epc_out, req, exl_out
    );
endinterface

// File: rtl/cp0_unit.sv
// ---------------------------------------------------------------------------
// cp0_unit
// Coprocessor 0 for the M stage. It holds SR, Cause, EPC and PRId. Each
// cycle it decides whether to take an interrupt or an exception, and it
// raises the global flush request.
// Ports:
//   clk    : clock. All state changes on the rising edge.
//   reset  : synchronous, active-high reset.
//   bus    : cp0_unit_if.slave. It carries the mtc0/mfc0 access, the M-stage
//            PC, the delay-slot flag, the exception code, the interrupt
//            lines and eret in. It carries rdata, EPC, req and EXL out.
// ---------------------------------------------------------------------------
module cp0_unit #(
    parameter logic [31:0] PRID_VAL  = 32'h2024_0707,
    parameter logic [31:0] EPC_RESET = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       reset,
    cp0_unit_if.slave  bus
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // Only the implemented fields are stored. Reserved bits are rebuilt as
    // zero when the full registers are assembled.
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_excCode;
    logic [31:0] r_epc;

    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic        w_intReq;
    logic        w_excReq;
    logic        w_req;

    assign w_sr    = {16'h0000, r_im, 8'h00, r_exl, r_ie};
    assign w_cause = {r_bd, 15'h0000, r_ip, 3'b000, r_excCode, 2'b00};

    // Both requests are masked while a handler runs (EXL=1). An interrupt
    // wins over a pending exception, so ExcCode is 0 when both are present.
    assign w_intReq = r_ie & ~r_exl & (|(bus.hw_int & r_im));
    assign w_excReq = ~r_exl & (bus.exc_code_in != 5'd0);
    assign w_req    = w_intReq | w_excReq;

    assign bus.req     = w_req;
    assign bus.epc_out = r_epc;
    assign bus.exl_out = r_exl;

    // mfc0 read port. It shows the pre-edge register contents and has no
    // bypass from a write in the same cycle.
    always_comb begin
        bus.cp0_rdata = 32'h0000_0000;
        case (bus.cp0_addr)
            ADDR_SR:    bus.cp0_rdata = w_sr;
            ADDR_CAUSE: bus.cp0_rdata = w_cause;
            ADDR_EPC:   bus.cp0_rdata = r_epc;
            ADDR_PRID:  bus.cp0_rdata = PRID_VAL;
            default:    bus.cp0_rdata = 32'h0000_0000;
        endcase
    end

    // State update.
    // IP copies the interrupt lines every cycle.
    // Taking a request records the fault context. The mtc0 in that cycle
    // belongs to the faulting instruction, so it is discarded.
    // Without a request, an mtc0 applies first. A simultaneous eret then
    // clears EXL, so eret wins over an SR write of EXL=1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_im      <= 6'd0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= 6'd0;
            r_excCode <= 5'd0;
            r_epc     <= EPC_RESET;
        end else begin
            r_ip <= bus.hw_int;
            if (w_req) begin
                r_exl     <= 1'b1;
                r_bd      <= bus.bd_in;
                r_excCode <= w_intReq ? 5'd0 : bus.exc_code_in;
                r_epc     <= bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;
            end else begin
                if (bus.en && (bus.cp0_addr == ADDR_SR)) begin
                    r_im  <= bus.cp0_wdata[15:10];
                    r_exl <= bus.cp0_wdata[1];
                    r_ie  <= bus.cp0_wdata[0];
                end
                if (bus.en && (bus.cp0_addr == ADDR_EPC)) begin
                    r_epc <= bus.cp0_wdata;
                end
                if (bus.eret) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// ---------------------------------------------------------------------------
// tb_cp0_unit
// Self-checking bench for cp0_unit. It runs a directed sequence, then a
// randomized one. Every cycle is checked against a word-level model of
// SR/Cause/EPC kept in the bench.
// ---------------------------------------------------------------------------
module tb_cp0_unit;

    localparam logic [31:0] PRID      = 32'h2024_0707;
    localparam logic [31:0] EPC_INIT  = 32'h0000_0000;

    logic clk;
    logic reset;

    cp0_unit_if bus ();

    cp0_unit #(
        .PRID_VAL  (PRID),
        .EPC_RESET (EPC_INIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model state, held as whole 32-bit words.
    logic [31:0] mSr;
    logic [31:0] mCause;
    logic [31:0] mEpc;
    logic        modelValid;

    // Outputs observed in the most recent applyStimulus cycle.
    logic [31:0] obsRdata;
    logic [31:0] obsEpc;
    logic        obsReq;
    logic        obsExl;

    // Counts one comparison and reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs on the falling edge and checks the
    // combinational outputs against the model. After the rising edge it
    // advances the model by the architectural rules.
    task automatic applyStimulus(input logic rst, input logic en,
                                 input logic [4:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] vpc, input logic bd,
                                 input logic [4:0] exc, input logic [5:0] hw,
                                 input logic eret);
        logic        expInt;
        logic        expExc;
        logic        expReq;
        logic [31:0] expRd;
        @(negedge clk);
        reset           = rst;
        bus.en          = en;
        bus.cp0_addr    = addr;
        bus.cp0_wdata   = wdata;
        bus.vpc         = vpc;
        bus.bd_in       = bd;
        bus.exc_code_in = exc;
        bus.hw_int      = hw;
        bus.eret        = eret;
        #1;
        obsRdata = bus.cp0_rdata;
        obsEpc   = bus.epc_out;
        obsReq   = bus.req;
        obsExl   = bus.exl_out;

        expInt = mSr[0] && !mSr[1] && ((hw & mSr[15:10]) != 6'd0);
        expExc = !mSr[1] && (exc != 5'd0);
        expReq = expInt || expExc;
        if (addr == 5'd12)      expRd = mSr;
        else if (addr == 5'd13) expRd = mCause;
        else if (addr == 5'd14) expRd = mEpc;
        else if (addr == 5'd15) expRd = PRID;
        else                    expRd = 32'h0;

        if (modelValid) begin
            checkOutput("req",   {31'd0, obsReq}, {31'd0, expReq});
            checkOutput("rdata", obsRdata, expRd);
            checkOutput("epc",   obsEpc, mEpc);
            checkOutput("exl",   {31'd0, obsExl}, {31'd0, mSr[1]});
        end

        @(posedge clk);
        #1;
        if (rst) begin
            mSr        = 32'h0;
            mCause     = 32'h0;
            mEpc       = EPC_INIT;
            modelValid = 1'b1;
        end else begin
            mCause = (mCause & ~32'h0000_FC00) | (32'(hw) << 10);
            if (expReq) begin
                mSr    = mSr | 32'h2;
                mCause = (mCause & ~32'h8000_007C) | (32'(bd) << 31)
                         | (expInt ? 32'h0 : (32'(exc) << 2));
                mEpc   = bd ? vpc - 32'd4 : vpc;
            end else begin
                if (en && addr == 5'd12) mSr  = wdata & 32'h0000_FC03;
                if (en && addr == 5'd14) mEpc = wdata;
                if (eret)                mSr  = mSr & ~32'h2;
            end
        end
    endtask

    // Runs a cycle that changes nothing except Cause.IP and selects addr
    // for reading.
    task automatic idleRead(input logic [4:0] addr, input logic [5:0] hw);
        applyStimulus(1'b0, 1'b0, addr, 32'h0, 32'h0, 1'b0, 5'd0, hw, 1'b0);
    endtask

    initial begin
        logic [4:0]  rAddr;
        logic [31:0] rWdata;
        logic [5:0]  rHw;
        logic [4:0]  rExc;
        int          sel;

        vectors     = 0;
        miscompares = 0;
        modelValid  = 1'b0;
        mSr         = 32'h0;
        mCause      = 32'h0;
        mEpc        = 32'h0;

        // Reset, then check the reset view of every register.
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        idleRead(5'd12, 6'd0);
        checkOutput("rst_sr", obsRdata, 32'h0);
        checkOutput("rst_req", {31'd0, obsReq}, 32'h0);
        idleRead(5'd13, 6'd0);
        checkOutput("rst_cause", obsRdata, 32'h0);
        idleRead(5'd14, 6'd0);
        checkOutput("rst_epc", obsRdata, 32'h0);
        idleRead(5'd15, 6'd0);
        checkOutput("rst_prid", obsRdata, PRID);

        // Enabled interrupt, outside a delay slot.
        applyStimulus(1'b0, 1'b1, 5'd12, 32'h0000_0401, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_3010, 1'b0, 5'd0, 6'b000001, 1'b0);
        checkOutput("int_req", {31'd0, obsReq}, 32'h1);
        idleRead(5'd12, 6'd1);
        checkOutput("int_sr", obsRdata, 32'h0000_0403);
        checkOutput("int_req_masked", {31'd0, obsReq}, 32'h0);
        idleRead(5'd13, 6'd0);
        checkOutput("int_cause", obsRdata, 32'h0000_0400);
        idleRead(5'd14, 6'd0);
        checkOutput("int_epc", obsRdata, 32'h0000_3010);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);

        // Exception raised in a branch delay slot.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_3008, 1'b1, 5'd4, 6'd0, 1'b0);
        checkOutput("exc_req", {31'd0, obsReq}, 32'h1);
        idleRead(5'd14, 6'd0);
        checkOutput("exc_epc", obsRdata, 32'h0000_3004);
        checkOutput("exc_exl", {31'd0, obsExl}, 32'h1);
        idleRead(5'd13, 6'd0);
        checkOutput("exc_cause", obsRdata, 32'h8000_0010);

        // Requests are ignored while EXL is set.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_5000, 1'b0, 5'd10, 6'h3F, 1'b0);
        checkOutput("exl_mask", {31'd0, obsReq}, 32'h0);
        idleRead(5'd14, 6'd0);
        checkOutput("exl_epc", obsRdata, 32'h0000_3004);
        idleRead(5'd13, 6'd0);
        checkOutput("exl_cause", obsRdata, 32'h8000_0010);

        // eret clears EXL, and a pending interrupt then fires at once.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'd1, 1'b1);
        idleRead(5'd0, 6'd1);
        checkOutput("eret_exl", {31'd0, obsExl}, 32'h0);
        checkOutput("eret_int", {31'd0, obsReq}, 32'h1);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);

        // An mtc0 in the faulting cycle is dropped. SR keeps only its
        // implemented bits.
        applyStimulus(1'b0, 1'b1, 5'd14, 32'hDEAD_BEEF, 32'h0000_3020, 1'b0, 5'd12, 6'd0, 1'b0);
        idleRead(5'd14, 6'd0);
        checkOutput("drop_epc", obsRdata, 32'h0000_3020);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        idleRead(5'd12, 6'd0);
        checkOutput("sr_mask", obsRdata, 32'h0000_FC03);

        // An mtc0 to SR together with eret ends with EXL clear.
        applyStimulus(1'b0, 1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
        idleRead(5'd12, 6'd0);
        checkOutput("mtc0_eret", obsRdata, 32'h0000_FC01);

        // Reset taken in the middle of a handler.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_4000, 1'b0, 5'd8, 6'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0000_4004, 1'b0, 5'd9, 6'h3F, 1'b0);
        idleRead(5'd12, 6'd0);
        checkOutput("mid_rst_exl", {31'd0, obsExl}, 32'h0);
        checkOutput("mid_rst_sr", obsRdata, 32'h0);

        // Randomized traffic, biased toward the CP0 register numbers and
        // occasional faults, interrupts and erets.
        for (int i = 0; i < 3000; i++) begin
            sel    = $urandom_range(0, 5);
            rAddr  = (sel < 4) ? 5'(12 + sel) : 5'($urandom_range(0, 31));
            rWdata = $urandom;
            if ($urandom_range(0, 2) == 0) rWdata[0] = 1'b1;
            rHw    = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            rExc   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 2) == 0),
                          rAddr, rWdata, $urandom, 1'($urandom), rExc, rHw,
                          ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
